// File: rtl/byte_pipe_ctrl.sv
// byte_pipe_ctrl: issue/sequencing controller for the even-pipe byte unit
// (absdb, avgb, cntb, sumb).
//   - Stage 1 registers the issued op and drives the external combinational
//     byte ALU through alu_instr_id / alu_ra / alu_rb.
//   - On the stage 1->2 edge alu_result is captured with the target register.
//   - Stages 2..LATENCY shift {valid, rt, data}; the last stage is the
//     register-file writeback port (wb_*).
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   issue_*               issue-stage request; issue_ready = ~stall
//   stall, flush          freeze the pipe / kill everything in flight
//   alu_* / alu_result    byte ALU operand registers and its result
//   wb_valid/wb_rt/wb_data writeback strobe, address, data
//   illegal_op            one-cycle pulse after an unsupported ID is taken
//   busy                  any stage holds a valid op
// Optional feature: define BYTE_PIPE_PERF_EN to add perf_clr / perf_issued,
// a 32-bit wrapping count of accepted legal issues.
// LATENCY legal range is 2..8.
module byte_pipe_ctrl #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned RT_W    = 7,
  localparam int unsigned ID_W   = 7,
  localparam int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ID_W-1:0]   issue_instr_id,
  input  logic [RT_W-1:0]   issue_rt,
  input  logic [DATA_W-1:0] issue_ra,
  input  logic [DATA_W-1:0] issue_rb,
  output logic              issue_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [ID_W-1:0]   alu_instr_id,
  output logic [DATA_W-1:0] alu_ra,
  output logic [DATA_W-1:0] alu_rb,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [RT_W-1:0]   wb_rt,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal_op,
`ifdef BYTE_PIPE_PERF_EN
  input  logic              perf_clr,
  output logic [31:0]       perf_issued,
`endif
  output logic              busy
);

  // Byte-class instruction IDs (mirrors opcode_package.vh).
  localparam logic [ID_W-1:0] INSTR_ID_ABSDB = 7'h0A;
  localparam logic [ID_W-1:0] INSTR_ID_AVGB  = 7'h0B;
  localparam logic [ID_W-1:0] INSTR_ID_CNTB  = 7'h0C;
  localparam logic [ID_W-1:0] INSTR_ID_SUMB  = 7'h0D;

  logic              legal_c;
  logic              s1_valid;
  logic [RT_W-1:0]   s1_rt;
  logic              sv     [2:LATENCY];
  logic [RT_W-1:0]   s_rt   [2:LATENCY];
  logic [DATA_W-1:0] s_data [2:LATENCY];
  logic [LATENCY:1]  valid_bits;

  // Supported-ID decode.
  always_comb begin
    legal_c = 1'b0;
    case (issue_instr_id)
      INSTR_ID_ABSDB, INSTR_ID_AVGB, INSTR_ID_CNTB, INSTR_ID_SUMB: legal_c = 1'b1;
      default: legal_c = 1'b0;
    endcase
  end

  assign issue_ready = ~stall;

  // Stage 1: operands load on every unstalled cycle (even for rejected IDs)
  // so the ALU never sees stale operands; only legal issues become valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_rt        <= '0;
      alu_instr_id <= '0;
      alu_ra       <= '0;
      alu_rb       <= '0;
      illegal_op   <= 1'b0;
    end else begin
      if (!stall) begin
        alu_instr_id <= issue_instr_id;
        alu_ra       <= issue_ra;
        alu_rb       <= issue_rb;
        s1_rt        <= issue_rt;
      end
      if (flush)       s1_valid <= 1'b0;
      else if (!stall) s1_valid <= issue_valid & legal_c;
      illegal_op <= issue_valid & ~stall & ~flush & ~legal_c;
    end
  end

  // Stage 2: capture ALU result alongside its destination register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv[2]     <= 1'b0;
      s_rt[2]   <= '0;
      s_data[2] <= '0;
    end else begin
      if (!stall) begin
        s_rt[2]   <= s1_rt;
        s_data[2] <= alu_result;
      end
      if (flush)       sv[2] <= 1'b0;
      else if (!stall) sv[2] <= s1_valid;
    end
  end

  // Stages 3..LATENCY: plain shift of {valid, rt, data}.
  for (genvar k = 3; k <= LATENCY; k++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sv[k]     <= 1'b0;
        s_rt[k]   <= '0;
        s_data[k] <= '0;
      end else begin
        if (!stall) begin
          s_rt[k]   <= s_rt[k-1];
          s_data[k] <= s_data[k-1];
        end
        if (flush)       sv[k] <= 1'b0;
        else if (!stall) sv[k] <= sv[k-1];
      end
    end
  end

  // Occupancy vector for busy.
  assign valid_bits[1] = s1_valid;
  for (genvar k = 2; k <= LATENCY; k++) begin : g_vbits
    assign valid_bits[k] = sv[k];
  end
  assign busy = |valid_bits;

  // Writeback is masked while stalled so the held op is written exactly once.
  assign wb_valid = sv[LATENCY] & ~stall;
  assign wb_rt    = s_rt[LATENCY];
  assign wb_data  = s_data[LATENCY];

`ifdef BYTE_PIPE_PERF_EN
  // Accepted legal issue counter; clear beats increment, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                perf_issued <= '0;
    else if (perf_clr)                         perf_issued <= '0;
    else if (issue_valid && !stall && legal_c) perf_issued <= perf_issued + 32'(1);
  end
`endif

endmodule

// File: tb/tb_byte_pipe_ctrl.sv
// Table-driven bench for byte_pipe_ctrl with a writeback scoreboard and a
// behavioural byte ALU attached to the alu_* outputs.
module tb_byte_pipe_ctrl;

  localparam int unsigned LAT = 4;
  localparam logic [6:0] ID_ABSDB = 7'h0A;
  localparam logic [6:0] ID_AVGB  = 7'h0B;
  localparam logic [6:0] ID_CNTB  = 7'h0C;
  localparam logic [6:0] ID_SUMB  = 7'h0D;
  localparam logic [6:0] ID_BAD   = 7'h7F;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         issue_valid;
  logic [6:0]   issue_instr_id;
  logic [6:0]   issue_rt;
  logic [127:0] issue_ra, issue_rb;
  logic         issue_ready;
  logic         stall, flush;
  logic [6:0]   alu_instr_id;
  logic [127:0] alu_ra, alu_rb, alu_result;
  logic         wb_valid;
  logic [6:0]   wb_rt;
  logic [127:0] wb_data;
  logic         illegal_op;
  logic         busy;
`ifdef BYTE_PIPE_PERF_EN
  logic         perf_clr;
  logic [31:0]  perf_issued;
`endif

  byte_pipe_ctrl #(.LATENCY(LAT), .RT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_instr_id(issue_instr_id),
    .issue_rt(issue_rt), .issue_ra(issue_ra), .issue_rb(issue_rb),
    .issue_ready(issue_ready), .stall(stall), .flush(flush),
    .alu_instr_id(alu_instr_id), .alu_ra(alu_ra), .alu_rb(alu_rb),
    .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_data(wb_data),
    .illegal_op(illegal_op),
`ifdef BYTE_PIPE_PERF_EN
    .perf_clr(perf_clr), .perf_issued(perf_issued),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte-op reference; byte i of a 128-bit operand is bits [127-8i -: 8].
  function automatic logic [127:0] byte_op(input logic [6:0] id, input logic [127:0] a,
                                           input logic [127:0] b);
    logic [127:0] r;
    logic [7:0]   x, y;
    logic [15:0]  sa, sb;
    r = '0;
    case (id)
      ID_ABSDB, ID_AVGB, ID_CNTB:
        for (int i = 0; i < 16; i++) begin
          x = a[127-8*i -: 8];
          y = b[127-8*i -: 8];
          if (id == ID_ABSDB)     r[127-8*i -: 8] = (x > y) ? 8'(x - y) : 8'(y - x);
          else if (id == ID_AVGB) r[127-8*i -: 8] = 8'((9'(x) + 9'(y) + 9'd1) >> 1);
          else                    r[127-8*i -: 8] = 8'($countones(x));
        end
      ID_SUMB:
        for (int w = 0; w < 4; w++) begin
          sa = '0;
          sb = '0;
          for (int j = 0; j < 4; j++) begin
            sa = sa + 16'(a[127-8*(4*w+j) -: 8]);
            sb = sb + 16'(b[127-8*(4*w+j) -: 8]);
          end
          r[127-32*w -: 16] = sb;
          r[111-32*w -: 16] = sa;
        end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb alu_result = byte_op(alu_instr_id, alu_ra, alu_rb);

  function automatic logic [127:0] make_op(input logic [7:0] seed, input logic [7:0] step);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = 8'(seed + step * 8'(i));
    return r;
  endfunction

  function automatic logic is_legal(input logic [6:0] id);
    return (id == ID_ABSDB) || (id == ID_AVGB) || (id == ID_CNTB) || (id == ID_SUMB);
  endfunction

  typedef struct {
    logic       rst;
    logic       v;
    logic [6:0] id;
    logic [6:0] rt;
    logic [7:0] a, sa, b, sb;
    logic       st, fl;
    logic       er, ew, eb, ei;
    logic       chk;
    logic [7:0] ebyte;
  } vec_t;

  typedef struct {
    logic [6:0]   rt;
    logic [127:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [6:0] id, input logic [6:0] rt,
                     input logic [7:0] a, input logic [7:0] sa, input logic [7:0] b,
                     input logic [7:0] sb, input logic st, input logic fl,
                     input logic ew, input logic eb, input logic ei);
    vec_t r;
    r.rst = 1'b0; r.v = v; r.id = id; r.rt = rt;
    r.a = a; r.sa = sa; r.b = b; r.sb = sb;
    r.st = st; r.fl = fl;
    r.er = ~st; r.ew = ew; r.eb = eb; r.ei = ei;
    r.chk = 1'b0; r.ebyte = '0;
    tbl.push_back(r);
  endtask

  task automatic idle(input logic ew, input logic eb, input logic ei);
    add(1'b0, 7'd0, 7'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, ew, eb, ei);
  endtask

  task automatic reset_row();
    idle(1'b0, 1'b0, 1'b0);
    tbl[tbl.size()-1].rst = 1'b1;
  endtask

  task automatic chk_last(input logic [7:0] byt);
    tbl[tbl.size()-1].chk   = 1'b1;
    tbl[tbl.size()-1].ebyte = byt;
  endtask

  // Drive one cycle at the falling edge, compare mid-cycle, update scoreboard.
  task automatic apply(input int idx, input vec_t r);
    exp_t e;
    logic [127:0] rep;
    @(negedge clk);
    rst_n          = ~r.rst;
    issue_valid    = r.v;
    issue_instr_id = r.id;
    issue_rt       = r.rt;
    issue_ra       = make_op(r.a, r.sa);
    issue_rb       = make_op(r.b, r.sb);
    stall          = r.st;
    flush          = r.fl;
    #1;
    check($sformatf("row%0d.issue_ready", idx), 128'(issue_ready), 128'(r.er));
    check($sformatf("row%0d.wb_valid", idx), 128'(wb_valid), 128'(r.ew));
    check($sformatf("row%0d.busy", idx), 128'(busy), 128'(r.eb));
    check($sformatf("row%0d.illegal_op", idx), 128'(illegal_op), 128'(r.ei));
    if (wb_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check($sformatf("row%0d.unexpected_wb", idx), 128'(1), 128'(0));
      end else begin
        e = sb_q.pop_front();
        check($sformatf("row%0d.wb_rt", idx), 128'(wb_rt), 128'(e.rt));
        check($sformatf("row%0d.wb_data", idx), wb_data, e.data);
      end
      if (r.chk) begin
        rep = {16{r.ebyte}};
        check($sformatf("row%0d.wb_bytes", idx), wb_data, rep);
      end
    end
    if (r.rst || r.fl) sb_q.delete();
    else if (r.v && !r.st && is_legal(r.id)) begin
      e.rt   = r.rt;
      e.data = byte_op(r.id, issue_ra, issue_rb);
      sb_q.push_back(e);
    end
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_instr_id = '0; issue_rt = '0;
    issue_ra = '0; issue_rb = '0; stall = 1'b0; flush = 1'b0;
`ifdef BYTE_PIPE_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("reset.wb_valid", 128'(wb_valid), 128'(0));
    check("reset.busy", 128'(busy), 128'(0));
    check("reset.illegal_op", 128'(illegal_op), 128'(0));
    check("reset.wb_rt", 128'(wb_rt), 128'(0));
    check("reset.wb_data", wb_data, 128'(0));
    check("reset.alu_ra", alu_ra, 128'(0));
    check("reset.alu_instr_id", 128'(alu_instr_id), 128'(0));

    // Single absdb: 0x10 vs 0x30 -> 0x20, writeback at cycle 4.
    add(1, ID_ABSDB, 7'd5, 8'h10, 8'h00, 8'h30, 8'h00, 0, 0, 0, 0, 0);
    idle(0, 1, 0); idle(0, 1, 0); idle(0, 1, 0);
    idle(1, 1, 0); chk_last(8'h20);
    idle(0, 0, 0);
    // Back-to-back four ops.
    add(1, ID_ABSDB, 7'd1, 8'h05, 8'h11, 8'h80, 8'h07, 0, 0, 0, 0, 0);
    add(1, ID_AVGB,  7'd2, 8'hF0, 8'h03, 8'h11, 8'h09, 0, 0, 0, 1, 0);
    add(1, ID_CNTB,  7'd3, 8'h00, 8'h1D, 8'h00, 8'h00, 0, 0, 0, 1, 0);
    add(1, ID_SUMB,  7'd4, 8'hFE, 8'h01, 8'h40, 8'h13, 0, 0, 0, 1, 0);
    idle(1, 1, 0); idle(1, 1, 0); idle(1, 1, 0); idle(1, 1, 0);
    idle(0, 0, 0);
    // cntb of 0xFF with stall in cycles 2-4 -> single writeback at cycle 7.
    add(1, ID_CNTB, 7'd9, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    idle(0, 1, 0);
    add(0, 7'd0, 7'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    add(0, 7'd0, 7'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    add(1, ID_AVGB, 7'd40, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    idle(0, 1, 0); idle(0, 1, 0);
    idle(1, 1, 0); chk_last(8'h08);
    idle(0, 0, 0);
    // Flush in cycle 2 with three issues, then flush together with stall.
    for (int m = 0; m < 2; m++) begin
      add(1, ID_ABSDB, 7'd20, 8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0, 0);
      add(1, ID_AVGB,  7'd21, 8'h21, 8'h02, 8'h33, 8'h04, 0, 0, 0, 1, 0);
      add(1, ID_CNTB,  7'd22, 8'h5A, 8'h02, 8'h00, 8'h04, 1'(m), 1, 0, 1, 0);
      for (int c = 3; c <= 8; c++) idle(0, 0, 0);
    end
    // Unsupported ID, then a legal op in the next cycle.
    add(1, ID_BAD,   7'd12, 8'h11, 8'h01, 8'h22, 8'h01, 0, 0, 0, 0, 0);
    add(1, ID_ABSDB, 7'd13, 8'h9C, 8'h05, 8'h37, 8'h0B, 0, 0, 0, 0, 1);
    idle(0, 1, 0); idle(0, 1, 0); idle(0, 1, 0);
    idle(1, 1, 0);
    idle(0, 0, 0);
    // Unsupported ID under stall is not taken and raises nothing.
    add(1, ID_BAD, 7'd12, 8'h11, 8'h01, 8'h22, 8'h01, 1, 0, 0, 0, 0);
    idle(0, 0, 0);
    // Reset with two ops in flight.
    add(1, ID_ABSDB, 7'd30, 8'h44, 8'h01, 8'h12, 8'h02, 0, 0, 0, 0, 0);
    add(1, ID_AVGB,  7'd31, 8'h44, 8'h01, 8'h12, 8'h02, 0, 0, 0, 1, 0);
    reset_row();
    for (int c = 3; c <= 8; c++) idle(0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

`ifdef BYTE_PIPE_PERF_EN
    tbl.delete();
    reset_row();
    add(1, ID_ABSDB, 7'd50, 8'h01, 8'h01, 8'h02, 8'h02, 0, 0, 0, 0, 0);
    add(1, ID_CNTB,  7'd51, 8'h03, 8'h01, 8'h02, 8'h02, 0, 0, 0, 1, 0);
    add(1, ID_SUMB,  7'd52, 8'h05, 8'h01, 8'h02, 8'h02, 0, 0, 0, 1, 0);
    idle(0, 1, 0);
    idle(1, 1, 0); idle(1, 1, 0); idle(1, 1, 0);
    idle(0, 0, 0);
    apply(1000, tbl[0]);
    check("perf.after_reset", 128'(perf_issued), 128'(0));
    for (int i = 1; i < tbl.size(); i++) apply(1000 + i, tbl[i]);
    check("perf.three_issues", 128'(perf_issued), 128'(3));
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    check("perf.after_clr", 128'(perf_issued), 128'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_pipe_ctrl.md
Name: byte_pipe_ctrl

Overview:
Issue/sequencing controller for the even-pipe byte unit (absdb, avgb, cntb, sumb).
- Accepts byte-class instructions from the issue stage and drives the combinational byte ALU from a registered operand stage.
- Carries each result plus its target register address through a fixed-latency pipeline.
- Presents the result to the register-file writeback port.
- Handles stall, flush and unsupported-instruction rejection.

Parameters:
LATENCY, 4, total stages from issue to writeback; legal range 2..8
RT_W, 7, register address width (128-entry register file)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  byte instruction presented this cycle
issue_instr_id  input  7  instruction ID, encoded per opcode_package.vh
issue_rt  input  RT_W  destination register address
issue_ra  input  128  operand RA, bit 0 = MSB
issue_rb  input  128  operand RB
issue_ready  output  1  equals ~stall; issue is taken only when issue_valid && issue_ready
stall  input  1  freeze the whole pipe
flush  input  1  kill all in-flight and incoming ops
alu_instr_id  output  7  to byte ALU; stage-1 register
alu_ra  output  128  to byte ALU; stage-1 register
alu_rb  output  128  to byte ALU; stage-1 register
alu_result  input  128  from byte ALU, combinational from alu_* outputs
wb_valid  output  1  writeback strobe
wb_rt  output  RT_W  writeback address
wb_data  output  128  writeback data
illegal_op  output  1  one-cycle pulse when an unsupported ID is issued
busy  output  1  any stage valid

Behaviour:
Reset (async, rst_n=0):
- All stage valids, alu_*, wb_rt, wb_data and illegal_op clear to 0.
- wb_valid=0, busy=0.
- An assertion mid-operation discards every in-flight op.

Pipeline:
- Stage 1 registers {valid, instr_id, rt, ra, rb}.
- At stage 1→2, alu_result is captured together with rt.
- Stages 2..LATENCY shift {valid, rt, data}.
- wb_* outputs are the stage-LATENCY registers.
- Issue in cycle 0 gives wb_valid in cycle LATENCY. Back-to-back issue sustains one op per cycle.

Supported IDs: instr_ID_absdb, instr_ID_avgb, instr_ID_cntb, instr_ID_sumb.
- Any other ID with issue_valid && issue_ready: the op is not inserted (stage-1 valid=0) and illegal_op pulses in the next cycle.
- alu_instr_id/ra/rb still load, so the ALU case never sees stale operands.

Stall=1:
- No stage advances and all registers hold. issue_ready=0, so the incoming op is not taken.
- wb_valid is forced 0 while stalled. The held last stage re-presents after stall drops, so writeback occurs exactly once.
- illegal_op is not raised.

Flush=1 at an edge:
- All stage valids are cleared, and the same-cycle issue is discarded.
- Flush wins over stall.
- wb_valid is 0 in the following cycle.
- Data/rt registers need not clear.

Invalid stages: data registers may load freely. wb_valid depends on valid only.

busy = OR of all stage valids, combinational.

Optional Feature:
BYTE_PIPE_PERF_EN:
- When defined, adds output perf_issued (32) and input perf_clr (1).
- perf_issued counts accepted legal issues and wraps 0xFFFFFFFF→0.
- perf_clr synchronously zeroes the counter, with priority over increment.
- Reset zeroes it. Flushed ops remain counted.
- When undefined, neither port exists and there is no counter logic.

Test Plan:
1. Reset then issue one absdb: rt=5, ra=all bytes 0x10, rb=all bytes 0x30, cycle 0 -> wb_valid only in cycle 4 (LATENCY=4), wb_rt=5, wb_data=all bytes 0x20; busy high cycles 1-4.
2. Four back-to-back issues (absdb, avgb, cntb, sumb), rt=1..4 -> wb_valid in cycles 4,5,6,7 with rt 1,2,3,4 in order and each data matching the byte-op reference model.
3. Issue cntb rt=9 with ra=all 0xFF in cycle 0, stall high cycles 2-4 -> issue_ready low cycles 2-4, single wb in cycle 7 with wb_rt=9 and every byte 0x08.
4. Issue ops in cycles 0,1,2, flush in cycle 2 -> no wb_valid in cycles 3-8 and busy=0 from cycle 3; flush together with stall behaves the same.
5. Issue an ID outside the four supported (e.g. the ID of a non-byte op) with rt=12 -> illegal_op=1 in cycle 1 only, no wb; a legal op issued in the next cycle writes back normally.
6. rst_n pulsed low in cycle 2 with two ops in flight -> wb_valid, busy and illegal_op all 0 immediately and no stale writeback afterwards; with BYTE_PIPE_PERF_EN, perf_issued=0 after reset, 3 after three legal issues, 0 the cycle after perf_clr.
